// File: rtl/soc_now_gpio_bank.sv
// Wishbone GPIO bank: direction/output registers, input synchronisers,
// and edge-detect interrupts with write-1-to-clear status.
module soc_now_gpio_bank #(
  parameter int          NUM_PINS    = 32,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                wbs_stb_i,
  input  logic                wbs_cyc_i,
  input  logic                wbs_we_i,
  input  logic [3:0]          wbs_sel_i,
  input  logic [31:0]         wbs_adr_i,
  input  logic [31:0]         wbs_dat_i,
  output logic                wbs_ack_o,
  output logic [31:0]         wbs_dat_o,
  input  logic [NUM_PINS-1:0] gpio_i,
  output logic [NUM_PINS-1:0] gpio_o,
  output logic [NUM_PINS-1:0] gpio_oeb,
  output logic                irq_o
);

  localparam logic [2:0] A_DIN  = 3'd0;
  localparam logic [2:0] A_DOUT = 3'd1;
  localparam logic [2:0] A_OEN  = 3'd2;
  localparam logic [2:0] A_RISE = 3'd3;
  localparam logic [2:0] A_FALL = 3'd4;
  localparam logic [2:0] A_STAT = 3'd5;
  localparam logic [2:0] A_SET  = 3'd6;
  localparam logic [2:0] A_CLR  = 3'd7;

  logic [NUM_PINS-1:0] r_sync [SYNC_STAGES];
  logic [NUM_PINS-1:0] r_prev;
  logic [NUM_PINS-1:0] r_dout;
  logic [NUM_PINS-1:0] r_oen;
  logic [NUM_PINS-1:0] r_rise;
  logic [NUM_PINS-1:0] r_fall;
  logic [NUM_PINS-1:0] r_stat;
  logic                r_ack;
  logic [31:0]         r_rdata;

  logic                w_hit;
  logic                w_req;
  logic                w_wr;
  logic [2:0]          w_off;
  logic [31:0]         w_bmask;
  logic [NUM_PINS-1:0] w_m;
  logic [NUM_PINS-1:0] w_d;
  logic [NUM_PINS-1:0] w_s;
  logic [NUM_PINS-1:0] w_evt;
  logic [31:0]         w_rd;
  logic                w_unused;

  assign w_hit   = wbs_adr_i[31:5] == BASE_ADDR[31:5];
  assign w_req   = wbs_cyc_i & wbs_stb_i & w_hit & ~r_ack;
  assign w_wr    = w_req & wbs_we_i;
  assign w_off   = wbs_adr_i[4:2];
  assign w_bmask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                    {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
  assign w_m     = NUM_PINS'(w_bmask);
  assign w_d     = NUM_PINS'(wbs_dat_i & w_bmask);
  assign w_s     = r_sync[SYNC_STAGES-1];
  assign w_evt   = (w_s & ~r_prev & r_rise)
                 | (~w_s & r_prev & r_fall);
  assign w_unused = &{1'b0, wbs_adr_i[1:0]};

  always_comb begin
    w_rd = '0;
    case (w_off)
      A_DIN:   w_rd = 32'(w_s);
      A_DOUT:  w_rd = 32'(r_dout);
      A_OEN:   w_rd = 32'(r_oen);
      A_RISE:  w_rd = 32'(r_rise);
      A_FALL:  w_rd = 32'(r_fall);
      A_STAT:  w_rd = 32'(r_stat);
      default: w_rd = '0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= gpio_i;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  // Edge events are merged into STATUS every cycle; a clear never hides
  // an event arriving on the same edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_prev  <= '0;
      r_dout  <= '0;
      r_oen   <= '0;
      r_rise  <= '0;
      r_fall  <= '0;
      r_stat  <= '0;
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_prev  <= w_s;
      r_ack   <= w_req;
      r_rdata <= (w_req & ~wbs_we_i) ? w_rd : '0;
      r_stat  <= r_stat | w_evt;
      if (w_wr) begin
        case (w_off)
          A_DOUT:  r_dout <= (r_dout & ~w_m) | w_d;
          A_OEN:   r_oen  <= (r_oen  & ~w_m) | w_d;
          A_RISE:  r_rise <= (r_rise & ~w_m) | w_d;
          A_FALL:  r_fall <= (r_fall & ~w_m) | w_d;
          A_STAT:  r_stat <= (r_stat & ~w_d) | w_evt;
          A_SET:   r_dout <= r_dout | w_d;
          A_CLR:   r_dout <= r_dout & ~w_d;
          default: ;
        endcase
      end
    end
  end

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_rdata;
  assign gpio_o    = r_dout;
  assign gpio_oeb  = ~r_oen;
  assign irq_o     = |r_stat;

endmodule

// File: tb/tb_soc_now_gpio_bank.sv
// Bench for soc_now_gpio_bank: 32-pin and 8-pin instances on one bus,
// read data checked through an expected-value queue.
module tb_soc_now_gpio_bank;

  localparam int          SS = 2;
  localparam logic [31:0] B0 = 32'h3000_0000;
  localparam logic [31:0] B1 = 32'h3000_0100;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0, wdat = '0;
  logic [31:0] gpio_i = '1;

  logic        ack_a, ack_b, irq_a, irq_b;
  logic [31:0] dat_a, dat_b, go_a, oeb_a;
  logic [7:0]  go_b, oeb_b;
  logic        ack;
  logic [31:0] dat;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  assign ack = ack_a | ack_b;
  assign dat = dat_a | dat_b;

  always #5 clock = ~clock;

  soc_now_gpio_bank #(.NUM_PINS(32), .SYNC_STAGES(SS), .BASE_ADDR(B0)) dut_a (
    .clock(clock), .reset(reset),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat),
    .wbs_ack_o(ack_a), .wbs_dat_o(dat_a),
    .gpio_i(gpio_i), .gpio_o(go_a), .gpio_oeb(oeb_a), .irq_o(irq_a)
  );

  soc_now_gpio_bank #(.NUM_PINS(8), .SYNC_STAGES(SS), .BASE_ADDR(B1)) dut_b (
    .clock(clock), .reset(reset),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat),
    .wbs_ack_o(ack_b), .wbs_dat_o(dat_b),
    .gpio_i(gpio_i[7:0]), .gpio_o(go_b), .gpio_oeb(oeb_b), .irq_o(irq_b)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic wb_xfer(input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s,
                         output bit ok, output logic [31:0] rd);
    @(negedge clock);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    ok = 1'b0; rd = '0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      if (ack) begin
        ok = 1'b1; rd = dat;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input string nm);
    bit ok;
    logic [31:0] rd;
    wb_xfer(1'b1, a, d, s, ok, rd);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: write ack=0 required ack=1", nm);
    end
  endtask

  task automatic wb_read(input logic [31:0] a, input logic [31:0] e,
                         input string nm);
    bit ok;
    logic [31:0] rd, x;
    exp_q.push_back(e);
    wb_xfer(1'b0, a, '0, 4'hF, ok, rd);
    x = exp_q.pop_front();
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: read ack=0 required ack=1", nm);
    end else if (rd !== x) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, rd, x);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; gpio_i = '1;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (oeb_a !== '1 || oeb_b !== 8'hFF) begin
      errors++; $display("FAIL rst_oeb: got %h/%h required all 1s", oeb_a, oeb_b);
    end
    checks++;
    if (go_a !== '0 || go_b !== '0) begin
      errors++; $display("FAIL rst_out: got %h/%h required 0", go_a, go_b);
    end
    checks++;
    if (irq_a !== 1'b0 || ack !== 1'b0 || dat !== '0) begin
      errors++;
      $display("FAIL rst_bus: irq=%b ack=%b dat=%h required 0", irq_a, ack, dat);
    end
    @(negedge clock);
    reset = 1'b0;
    wb_read(B0 + 0, 32'h0, "din_early");
    repeat (SS) @(posedge clock);
    wb_read(B0 + 0, 32'hFFFF_FFFF, "din_synced");
  endtask

  task automatic test_output;
    wb_write(B0 + 8, 32'h0000_00FF, 4'hF, "oen_wr");
    wb_write(B0 + 4, 32'h0000_00A5, 4'hF, "dout_wr");
    checks++;
    if (oeb_a !== 32'hFFFF_FF00) begin
      errors++; $display("FAIL oeb: got %h required ffffff00", oeb_a);
    end
    checks++;
    if (go_a !== 32'h0000_00A5) begin
      errors++; $display("FAIL gpio_o: got %h required 000000a5", go_a);
    end
    wb_write(B0 + 24, 32'h2, 4'hF, "set_wr");
    wb_write(B0 + 28, 32'h1, 4'hF, "clr_wr");
    wb_read(B0 + 4, 32'h0000_00A6, "set_clr");
    wb_read(B0 + 24, 32'h0, "set_reads0");
  endtask

  task automatic test_byte_sel;
    wb_write(B0 + 4, 32'h0, 4'hF, "dout_zero");
    wb_write(B0 + 4, 32'h1122_3344, 4'b0010, "dout_byte");
    wb_read(B0 + 4, 32'h0000_3300, "byte_sel");
  endtask

  task automatic test_back_to_back;
    int n = 0;
    logic prev = 1'b0;
    @(negedge clock);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = B0 + 4; sel = 4'hF;
    exp_q.push_back(32'h0000_3300);
    exp_q.push_back(32'h0000_3300);
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      checks++;
      if (ack) begin
        logic [31:0] x;
        n++;
        x = exp_q.pop_front();
        if (prev || dat !== x) begin
          errors++;
          $display("FAIL b2b_ack%0d: dat=%h prev=%b required %h prev=0", i, dat, prev, x);
        end
      end else if (dat !== '0) begin
        errors++; $display("FAIL b2b_idle%0d: dat=%h required 0", i, dat);
      end
      prev = ack;
    end
    cyc = 1'b0; stb = 1'b0;
    checks++;
    if (n != 2) begin
      errors++; $display("FAIL b2b_count: got %0d acks required 2", n);
      exp_q.delete();
    end
  endtask

  task automatic test_irq;
    int at = -1;
    wb_write(B0 + 12, 32'h8, 4'hF, "rise_en");
    repeat (SS + 2) @(posedge clock);
    #1;
    checks++;
    if (irq_a !== 1'b0) begin
      errors++; $display("FAIL no_retro: irq=%b required 0", irq_a);
    end
    @(negedge clock); gpio_i = '0;
    repeat (SS + 2) @(posedge clock);
    @(negedge clock); gpio_i[3] = 1'b1;
    for (int i = 1; i <= SS + 1; i++) begin
      @(posedge clock); #1;
      if (irq_a && at < 0) at = i;
    end
    checks++;
    if (at != SS + 1) begin
      errors++; $display("FAIL irq_rise: set at cycle %0d required %0d", at, SS + 1);
    end
    wb_read(B0 + 20, 32'h8, "stat_rise");
    wb_write(B0 + 20, 32'h8, 4'hF, "w1c");
    checks++;
    if (irq_a !== 1'b0) begin
      errors++; $display("FAIL irq_clr: irq=%b required 0", irq_a);
    end
    @(negedge clock); gpio_i[3] = 1'b0;
    repeat (SS + 3) @(posedge clock);
    wb_read(B0 + 20, 32'h0, "no_fall_set");
  endtask

  task automatic test_fall;
    wb_write(B0 + 16, 32'h10, 4'hF, "fall_en");
    @(negedge clock); gpio_i[4] = 1'b1;
    repeat (SS + 3) @(posedge clock);
    #1;
    checks++;
    if (irq_a !== 1'b0) begin
      errors++; $display("FAIL fall_on_rise: irq=%b required 0", irq_a);
    end
    @(negedge clock); gpio_i[4] = 1'b0;
    repeat (SS + 3) @(posedge clock);
    wb_read(B0 + 20, 32'h10, "stat_fall");
    wb_write(B0 + 20, 32'h10, 4'hF, "w1c_fall");
    wb_read(B0 + 20, 32'h0, "stat_fall_clr");
  endtask

  task automatic test_collision;
    @(negedge clock); gpio_i[3] = 1'b1;
    repeat (SS) @(posedge clock);
    wb_write(B0 + 20, 32'h8, 4'hF, "w1c_coll");
    wb_read(B0 + 20, 32'h8, "coll_stat");
    checks++;
    if (irq_a !== 1'b1) begin
      errors++; $display("FAIL coll_irq: irq=%b required 1", irq_a);
    end
    wb_write(B0 + 20, 32'h8, 4'hF, "w1c_after");
    checks++;
    if (irq_a !== 1'b0) begin
      errors++; $display("FAIL coll_clr: irq=%b required 0", irq_a);
    end
  endtask

  task automatic test_offbase;
    bit ok;
    logic [31:0] rd;
    wb_xfer(1'b1, 32'h3000_0204, 32'hFFFF_FFFF, 4'hF, ok, rd);
    checks++;
    if (ok) begin
      errors++; $display("FAIL offbase_ack: ack=1 required no ack");
    end
    wb_read(B0 + 4, 32'h0000_3300, "offbase_noeffect");
  endtask

  task automatic test_param;
    wb_write(B1 + 4, 32'hFFFF_FFFF, 4'hF, "p8_wr");
    wb_read(B1 + 4, 32'h0000_00FF, "p8_dout");
    wb_read(B1 + 24, 32'h0, "p8_set_reads0");
    checks++;
    if (go_b !== 8'hFF) begin
      errors++; $display("FAIL p8_pins: got %h required ff", go_b);
    end
  endtask

  task automatic test_mid_reset;
    @(negedge clock);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = B0 + 4; sel = 4'hF;
    @(posedge clock); #1;
    checks++;
    if (ack !== 1'b1) begin
      errors++; $display("FAIL mid_ack: ack=%b required 1", ack);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (ack !== 1'b0 || oeb_a !== '1) begin
      errors++; $display("FAIL mid_rst: ack=%b oeb=%h required 0/ffffffff", ack, oeb_a);
    end
    cyc = 1'b0; stb = 1'b0;
    @(negedge clock); reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_output();
    test_byte_sel();
    test_back_to_back();
    test_irq();
    test_fall();
    test_collision();
    test_offbase();
    test_param();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/soc_now_gpio_bank.md
Name: soc_now_gpio_bank

Overview:
- Parametrised Wishbone-slave GPIO controller for the SoC-now Caravel user area.
- Replaces the fixed 32-pin, pass-through GPIO mapping with:
  - a configurable pin count;
  - per-pin direction and output registers;
  - input synchronisers;
  - edge-detect interrupts with write-1-to-clear status.
- Sits between the Caravel Wishbone bus / io pads and the user-IRQ line.

Parameters:
- NUM_PINS, 32, number of GPIO pins (1..32); register bits at and above NUM_PINS read 0 and ignore writes.
- SYNC_STAGES, 2, input synchroniser depth (2..4).
- BASE_ADDR, 32'h3000_0000, Wishbone base address; decode on wbs_adr_i[31:5] == BASE_ADDR[31:5].

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte selects.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- gpio_i  in  NUM_PINS  pad inputs (asynchronous).
- gpio_o  out  NUM_PINS  pad output values.
- gpio_oeb  out  NUM_PINS  pad output enables, active-low (1 = input).
- irq_o  out  1  level interrupt, high while any enabled status bit is set.

Behaviour:
- Clock, reset: one clock, named clock; reset is asynchronous and active-high, named reset.
- Reset values:
  - all registers, synchroniser flops and edge-history flops = 0;
  - wbs_ack_o = 0, wbs_dat_o = 0, gpio_o = 0;
  - gpio_oeb = all 1s (every pin an input), irq_o = 0.
- Register map (offset = wbs_adr_i[4:2]):
  - 0 DATA_IN (RO): synchronised inputs.
  - 1 DATA_OUT (RW).
  - 2 OUT_EN (RW): 1 = drive.
  - 3 RISE_EN (RW).
  - 4 FALL_EN (RW).
  - 5 IRQ_STATUS (R/W1C).
  - 6 OUT_SET (WO): DATA_OUT |= wdata; reads 0.
  - 7 OUT_CLR (WO): DATA_OUT &= ~wdata; reads 0.
- Byte writes: wbs_sel_i[n] gates byte n on every writable register, including the W1C, SET and CLR registers.
- Bus handshake:
  - Request = wbs_cyc_i & wbs_stb_i & address hit & !wbs_ack_o.
  - wbs_ack_o asserts one cycle after a request, for exactly one cycle.
  - Back-to-back requests therefore complete every 2 cycles.
  - Write takes effect on the same edge that asserts ack.
  - wbs_dat_o is valid while ack is high and 0 otherwise.
  - Address miss: no ack, no side effects.
- Outputs: gpio_o = DATA_OUT[NUM_PINS-1:0]; gpio_oeb = ~OUT_EN[NUM_PINS-1:0]. Both registered; they change on the write's ack edge.
- Input path:
  - gpio_i passes through SYNC_STAGES flops, giving s.
  - An edge-history flop p <= s every cycle.
  - DATA_IN = s.
  - Latency from the first capturing edge to DATA_IN: SYNC_STAGES cycles.
- Edge detection:
  - rise = s & ~p & RISE_EN;
  - fall = ~s & p & FALL_EN;
  - on each edge, STATUS <= STATUS | rise | fall.
  - Both enables set: both edges are flagged.
- W1C write: STATUS <= (STATUS & ~wmask) | rise | fall. A new event on the same edge as its clear wins (the bit stays 1).
- Disabling an enable does not clear STATUS.
- irq_o = |STATUS, combinational from the STATUS register; no extra cycle.
- Output pins are still sampled, so DATA_IN reflects driven pins via the pad loopback.
- Reset mid-transaction: ack drops immediately; the transaction is lost; the master must retry.
- A pin already high at reset release with RISE_EN = 0 sets no status. Enabling RISE_EN later does not retroactively flag that edge.

Test Plan:
- Reset:
  - hold reset with gpio_i = all 1s;
  - check: gpio_oeb = all 1s, gpio_o = 0, irq_o = 0, wbs_ack_o = 0;
  - after release, read DATA_IN → 32'hFFFF_FFFF only once SYNC_STAGES cycles have elapsed.
- Output control:
  - write OUT_EN = 32'h0000_00FF, then DATA_OUT = 32'h0000_00A5;
  - check: gpio_oeb[7:0] = 0, gpio_o[7:0] = 8'hA5;
  - write OUT_SET = 32'h2, then OUT_CLR = 32'h1 → DATA_OUT reads 32'h0000_00A6.
- Byte select: write DATA_OUT = 32'h1122_3344 with sel = 4'b0010 over 0 → reads 32'h0000_3300.
- Interrupts:
  - set RISE_EN[3] = 1, toggle gpio_i[3] 0→1;
  - check: STATUS[3] = 1 and irq_o = 1 within SYNC_STAGES + 1 cycles; no set on the 1→0 transition;
  - write STATUS = 32'h8 → irq_o = 0.
- Clear/event collision: schedule a W1C of bit 3 on the same edge as a new rising edge of pin 3 → STATUS[3] stays 1.
- Parametrisation:
  - with NUM_PINS = 8, write DATA_OUT = 32'hFFFF_FFFF → reads 32'h0000_00FF;
  - offset 6 reads 0;
  - an off-base address gives no ack within 4 cycles.
